acc_cpu_param: RTL and testbench
================================

// Module: acc_cpu_param
// PURPOSE
//   Parametrised accumulator CPU core: next generation of the 4-bit X/Y/Z-register CPU.
//   Adds selectable data width, a writable program memory, synchronous reset, and start/halt control.
//   Adds conditional jumps, zero/carry flags and an out_valid strobe.
//   Top-level compute block between the stimulus board inputs and the display outputs.
// PARAMETERS
//   WIDTH       4   data path width (X, Y/accumulator, Z, ALU, in_data, out_data)
//   ADDR_W      4   program counter width; memory depth = 2**ADDR_W; constraint ADDR_W <= WIDTH
// PORTS
//   clock          in   1            rising-edge clock
//   reset          in   1            synchronous, active-high
//   prog_we        in   1            program memory write enable (honoured only in IDLE/HALT)
//   prog_addr      in   ADDR_W       program write address
//   prog_data      in   4+WIDTH      instruction word {opcode[3:0], imm[WIDTH-1:0]}
//   start          in   1            level-sampled; IDLE/HALT -> FETCH with PC=0
//   in_data        in   WIDTH        external operand read by LDIN
//   out_data       out  WIDTH        register Z
//   out_valid      out  1            one-cycle pulse when Z is written
//   acc            out  WIDTH        register Y (accumulator)
//   pc             out  ADDR_W       program counter
//   flag_z, flag_c out  1            zero / carry(borrow) flags
//   current_state  out  3            FSM state code
//   busy           out  1            high in FETCH/EXEC/WB
//   halted         out  1            high in HALT
// BEHAVIOUR
//   Reset: state=IDLE(0), PC, X, Y, Z, flags=0, out_valid=0. Program memory is NOT cleared.
//   States: IDLE=0, FETCH=1, EXEC=2, WB=3, HALT=4. Codes 5-7 are illegal and go to IDLE next cycle.
//   IDLE/HALT + start=1 -> FETCH, PC<=0. A prog_we in the same cycle is written first and is visible to that fetch.
//   FETCH: IR <= mem[PC] (registered read) -> EXEC.
//   EXEC: ALU/X load per opcode -> WB.
//   WB: commit Y/Z/flags; PC <= next PC -> FETCH. HALT goes to HALT instead.
//   Each instruction takes exactly 3 cycles.
//   Opcodes (ALU ops use Y <= Y op X; flags update only on ALU ops):
//     0 NOP
//     1 LDI  X<=imm
//     2 LDIN X<=in_data
//     3 ADD  (C = carry out)
//     4 SUB  (C = borrow, Y<X)
//     5 AND
//     6 OR
//     7 XOR
//     8 NOT  Y<=~Y
//     9 SHL  (C = MSB out)
//     A SHR  (C = LSB out)
//     B MOV  Y<=X
//     C OUT  Z<=Y, out_valid=1 during the cycle after WB
//     D JMP  PC<=imm[ADDR_W-1:0]
//     E JZ   jump if flag_z else PC+1
//     F HALT
//   Z flag = (result == 0). Results wrap modulo 2**WIDTH. C is cleared by AND/OR/XOR/NOT/MOV.
//   PC increment wraps from 2**ADDR_W-1 to 0.
//   prog_we while busy is ignored (memory unchanged). start while busy is ignored.
//   reset mid-instruction aborts it: no Y/Z/flag commit, out_valid stays 0.
// TESTING
//   1. reset; load {LDI 3, MOV, LDI 5, ADD, OUT, HALT}; start
//      -> out_data=8, out_valid single pulse, halted=1 after 18 cycles, flag_c=0.
//   2. WIDTH=4: LDI F, MOV, LDI 1, ADD, OUT -> Y=0, flag_z=1, flag_c=1, out_data=0.
//   3. LDI 2, MOV, LDI 2, SUB, JZ 7 at addr 4; addr 7 = HALT
//      -> PC=7 then halted=1; addresses 5-6 never executed.
//   4. LDIN with in_data=9, MOV, OUT -> out_data=9. Also prog_we pulse while busy -> memory readback unchanged.
//   5. reset asserted in EXEC of an OUT
//      -> next cycle state=0, Z=0, out_valid=0. Program still present; a restart reproduces results.
//   6. Program of 16 NOPs with no HALT -> PC wraps 15->0; busy remains 1; state cycles 1,2,3.

Source files
------------

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: X operand, Y accumulator, Z output register,
// writable program memory and a 3-cycle FETCH/EXEC/WB instruction sequence.
module acc_cpu_param #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WIDTH+3:0]  prog_data,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  output logic [WIDTH-1:0]  acc,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic [2:0]        current_state,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StWb    = 3'd3,
    StHalt  = 3'd4
  } state_e;

  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpLdin = 4'h2;
  localparam logic [3:0] OpAdd  = 4'h3;
  localparam logic [3:0] OpSub  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpOr   = 4'h6;
  localparam logic [3:0] OpXor  = 4'h7;
  localparam logic [3:0] OpNot  = 4'h8;
  localparam logic [3:0] OpShl  = 4'h9;
  localparam logic [3:0] OpShr  = 4'hA;
  localparam logic [3:0] OpMov  = 4'hB;
  localparam logic [3:0] OpOut  = 4'hC;
  localparam logic [3:0] OpJmp  = 4'hD;
  localparam logic [3:0] OpJz   = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e              state_q, state_d;
  logic [WIDTH+3:0]    mem_q [2**ADDR_W];
  logic [WIDTH+3:0]    ir_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [WIDTH-1:0]    x_q, y_q, z_q, res_q;
  logic                fz_q, fc_q, res_c_q, ov_q;

  logic [3:0]          op;
  logic [WIDTH-1:0]    imm;
  logic [WIDTH:0]      sum, diff;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_c, alu_en, idle_like;

  assign op        = ir_q[WIDTH+3:WIDTH];
  assign imm       = ir_q[WIDTH-1:0];
  assign sum       = {1'b0, y_q} + {1'b0, x_q};
  assign diff      = {1'b0, y_q} - {1'b0, x_q};
  assign idle_like = (state_q == StIdle) || (state_q == StHalt);

  always_comb begin
    alu_res = y_q;
    alu_c   = 1'b0;
    alu_en  = 1'b1;
    case (op)
      OpAdd:   {alu_c, alu_res} = sum;
      OpSub:   {alu_c, alu_res} = diff;  // top bit of the extended difference is the borrow
      OpAnd:   alu_res = y_q & x_q;
      OpOr:    alu_res = y_q | x_q;
      OpXor:   alu_res = y_q ^ x_q;
      OpNot:   alu_res = ~y_q;
      OpShl: begin
        alu_res = y_q << 1;
        alu_c   = y_q[WIDTH-1];
      end
      OpShr: begin
        alu_res = y_q >> 1;
        alu_c   = y_q[0];
      end
      OpMov:   alu_res = x_q;
      default: alu_en  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StHalt: if (start) state_d = StFetch;
      StFetch:        state_d = StExec;
      StExec:         state_d = StWb;
      StWb:           state_d = (op == OpHalt) ? StHalt : StFetch;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Not reset: program survives a reset. Writes only land while the core is parked.
  always_ff @(posedge clock) begin
    if (prog_we && idle_like) mem_q[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q    <= '0;
      pc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      res_q   <= '0;
      res_c_q <= 1'b0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      case (state_q)
        StIdle, StHalt: if (start) pc_q <= '0;
        StFetch:        ir_q <= mem_q[pc_q];
        StExec: begin
          res_q   <= alu_res;
          res_c_q <= alu_c;
          if (op == OpLdi)  x_q <= imm;
          if (op == OpLdin) x_q <= in_data;
        end
        StWb: begin
          if (alu_en) begin
            y_q  <= res_q;
            fz_q <= (res_q == '0);
            fc_q <= res_c_q;
          end
          if (op == OpOut) begin
            z_q  <= y_q;
            ov_q <= 1'b1;
          end
          if (op == OpJmp || (op == OpJz && fz_q)) pc_q <= imm[ADDR_W-1:0];
          else if (op != OpHalt)                  pc_q <= pc_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data      = z_q;
  assign out_valid     = ov_q;
  assign acc           = y_q;
  assign pc            = pc_q;
  assign flag_z        = fz_q;
  assign flag_c        = fc_q;
  assign current_state = state_q;
  assign busy          = (state_q == StFetch) || (state_q == StExec) || (state_q == StWb);
  assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param (WIDTH=4, ADDR_W=4): program table plus
// hand sequences for restart, busy writes, mid-instruction reset and PC wrap.
module tb_acc_cpu_param;

  logic       clock = 1'b0;
  logic       reset, prog_we, start;
  logic [3:0] prog_addr, in_data;
  logic [7:0] prog_data;
  logic [3:0] out_data, acc, pc;
  logic       out_valid, flag_z, flag_c, busy, halted;
  logic [2:0] current_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  acc_cpu_param #(.WIDTH(4), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .in_data(in_data), .out_data(out_data),
    .out_valid(out_valid), .acc(acc), .pc(pc), .flag_z(flag_z), .flag_c(flag_c),
    .current_state(current_state), .busy(busy), .halted(halted)
  );

  // Program held as a flat word list; the first word written is the leftmost byte.
  typedef struct {
    logic [127:0] prog;
    int           n;
    logic [3:0]   in;
    int           cyc;
    logic [3:0]   acc;
    logic [3:0]   out;
    logic         fz;
    logic         fc;
    logic [3:0]   pc;
    int           pulses;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load(input logic [127:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = p[8*(n-i)-1 -: 8];
      @(negedge clock);
    end
    prog_we = 1'b0;
  endtask

  // Waits for halted after start; cycles excludes the edge that samples start.
  task automatic wait_halt(input int max, output int cycles, output int pulses,
                           output bit done);
    cycles = 0;
    pulses = 0;
    done   = 1'b0;
    while (!done && cycles < max) begin
      @(negedge clock);
      cycles++;
      if (out_valid) pulses++;
      if (halted) done = 1'b1;
    end
  endtask

  task automatic run(input int max, output int cycles, output int pulses, output bit done);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_halt(max, cycles, pulses, done);
  endtask

  function automatic vec_t mk(input logic [127:0] p, input int n, input logic [3:0] in,
                              input int cyc, input logic [3:0] a, input logic [3:0] o,
                              input logic fz, input logic fc, input logic [3:0] pcv,
                              input int pulses);
    vec_t v;
    v.prog = p; v.n = n; v.in = in; v.cyc = cyc; v.acc = a; v.out = o;
    v.fz = fz; v.fc = fc; v.pc = pcv; v.pulses = pulses;
    return v;
  endfunction

  initial begin
    int  cyc, pul;
    bit  done;

    reset = 1'b1; prog_we = 1'b0; start = 1'b0;
    prog_addr = '0; prog_data = '0; in_data = '0;
    repeat (2) @(negedge clock);
    chk("reset state", 32'(current_state), 0);
    chk("reset pc", 32'(pc), 0);
    chk("reset acc", 32'(acc), 0);
    chk("reset out", 32'(out_data), 0);
    chk("reset flags", 32'({flag_z, flag_c}), 0);
    chk("reset strobes", 32'({out_valid, busy, halted}), 0);
    reset = 1'b0;

    vecs[0] = mk({8'h13, 8'hB0, 8'h15, 8'h30, 8'hC0, 8'hF0}, 6, 4'h0, 18,
                 4'h8, 4'h8, 1'b0, 1'b0, 4'd5, 1);
    vecs[1] = mk({8'h1F, 8'hB0, 8'h11, 8'h30, 8'hC0, 8'hF0}, 6, 4'h0, 18,
                 4'h0, 4'h0, 1'b1, 1'b1, 4'd5, 1);
    vecs[2] = mk({8'h12, 8'hB0, 8'h15, 8'h40, 8'hC0, 8'hF0}, 6, 4'h0, 18,
                 4'hD, 4'hD, 1'b0, 1'b1, 4'd5, 1);
    vecs[3] = mk({8'h20, 8'hB0, 8'hC0, 8'hF0}, 4, 4'h9, 12,
                 4'h9, 4'h9, 1'b0, 1'b0, 4'd3, 1);
    vecs[4] = mk({8'h1C, 8'hB0, 8'h1A, 8'h50, 8'h13, 8'h60, 8'h16, 8'h70, 8'hC0, 8'hF0},
                 10, 4'h0, 30, 4'hD, 4'hD, 1'b0, 1'b0, 4'd9, 1);
    vecs[5] = mk({8'h19, 8'hB0, 8'h90, 8'hA0, 8'h80, 8'hC0, 8'hA0, 8'hA0, 8'hF0},
                 9, 4'h0, 27, 4'h3, 4'hE, 1'b0, 1'b1, 4'd8, 1);
    vecs[6] = mk({8'h12, 8'hB0, 8'h12, 8'h40, 8'hE7, 8'hC0, 8'hC0, 8'hF0}, 8, 4'h0, 18,
                 4'h0, 4'h0, 1'b1, 1'b0, 4'd7, 0);
    vecs[7] = mk({8'h12, 8'hB0, 8'h13, 8'h40, 8'hE7, 8'hC0, 8'hF0}, 7, 4'h0, 21,
                 4'hF, 4'hF, 1'b0, 1'b1, 4'd6, 1);
    vecs[8] = mk({8'hD3, 8'hC0, 8'hC0, 8'hF0}, 4, 4'h0, 6,
                 4'h0, 4'h0, 1'b0, 1'b0, 4'd3, 0);

    for (int k = 0; k < 9; k++) begin
      do_reset();
      load(vecs[k].prog, vecs[k].n);
      in_data = vecs[k].in;
      run(200, cyc, pul, done);
      chk($sformatf("v%0d halted", k), 32'(done), 1);
      chk($sformatf("v%0d cycles", k), cyc, vecs[k].cyc);
      chk($sformatf("v%0d acc", k), 32'(acc), 32'(vecs[k].acc));
      chk($sformatf("v%0d out_data", k), 32'(out_data), 32'(vecs[k].out));
      chk($sformatf("v%0d flag_z", k), 32'(flag_z), 32'(vecs[k].fz));
      chk($sformatf("v%0d flag_c", k), 32'(flag_c), 32'(vecs[k].fc));
      chk($sformatf("v%0d pc", k), 32'(pc), 32'(vecs[k].pc));
      chk($sformatf("v%0d pulses", k), pul, vecs[k].pulses);
    end

    // Write in the same cycle as start lands before the first fetch.
    do_reset();
    load({8'h11, 8'hB0, 8'hC0, 8'hF0}, 4);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h1A; start = 1'b1;
    @(negedge clock);
    prog_we = 1'b0; start = 1'b0;
    wait_halt(200, cyc, pul, done);
    chk("same-cycle write out", 32'(out_data), 32'hA);

    // Writes while busy are dropped; restart from HALT rereads the same program.
    do_reset();
    load({8'h20, 8'hB0, 8'hC0, 8'hF0}, 4);
    in_data = 4'h9;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hF0;
    repeat (2) @(negedge clock);
    prog_we = 1'b0;
    wait_halt(200, cyc, pul, done);
    chk("busy-write run1 out", 32'(out_data), 32'h9);
    in_data = 4'h6;
    run(200, cyc, pul, done);
    chk("busy-write run2 halted", 32'(done), 1);
    chk("busy-write run2 out", 32'(out_data), 32'h6);
    chk("busy-write run2 pulses", pul, 1);

    // Reset during EXEC of OUT (instruction 2) aborts it.
    do_reset();
    load({8'h17, 8'hB0, 8'hC0, 8'hF0}, 4);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    chk("abort in exec", 32'(current_state), 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort state", 32'(current_state), 0);
    chk("abort out_data", 32'(out_data), 0);
    chk("abort acc", 32'(acc), 0);
    chk("abort out_valid", 32'(out_valid), 0);
    @(negedge clock);
    chk("abort out_valid later", 32'(out_valid), 0);
    run(200, cyc, pul, done);
    chk("abort rerun out", 32'(out_data), 32'h7);
    chk("abort rerun pulses", pul, 1);

    // 16 NOPs, no HALT: PC wraps and the core never parks.
    do_reset();
    load(128'h0, 16);
    start = 1'b1;
    for (int i = 1; i <= 52; i++) begin
      @(negedge clock);
      start = 1'b0;
      chk($sformatf("nop state i=%0d", i), 32'(current_state), 32'(((i - 1) % 3) + 1));
      chk($sformatf("nop busy i=%0d", i), 32'(busy), 1);
      if (i == 48) chk("nop pc before wrap", 32'(pc), 15);
      if (i == 49) chk("nop pc after wrap", 32'(pc), 0);
    end
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
